// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial sequencer feeding a combinational 1-bit ALU slice.
// Presents one operand bit pair per cycle (LSB first), carries the slice carry
// between cycles and assembles a WIDTH-bit result with carry/zero/overflow flags.
// Optional feature macro: ALU_SERIAL_OVF_EN (signed overflow flag; tied 0 otherwise).
module alu_serial_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero,
   output logic             ovf,
   output logic [2:0]       alu_op,
   output logic             alu_a,
   output logic             alu_b,
   output logic             alu_cin,
   input  logic             alu_result,
   input  logic             alu_cout
);

   localparam logic [2:0] OP_MOVE = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b101;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, b_sh_q;
   // Only WIDTH-1 collected bits need storing; the final bit comes straight from the slice.
   logic [WIDTH-2:0] res_sh_q;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] result_q;
   logic [2:0]       op_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             carry_out_q;
   logic             zero_q;
   logic             last_bit;
   logic             is_sub;
   logic             is_arith;

   assign is_sub   = (op_q == OP_SUB);
   assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
   assign last_bit = (cnt_q == LAST_BIT);
   assign res_next = {alu_result, res_sh_q};

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic and state-decoded outputs; slice drive is gated to RUN.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      alu_op  = OP_MOVE;
      alu_a   = 1'b0;
      alu_b   = 1'b0;
      alu_cin = 1'b0;
      case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         S_RUN: begin
            busy    = 1'b1;
            alu_a   = a_sh_q[0];
            alu_b   = b_sh_q[0] ^ is_sub;   // SUB = A + ~B + 1
            alu_cin = carry_q;
            case (op_q)
               OP_SUB:         alu_op = OP_ADD;
               3'b110, 3'b111: alu_op = OP_MOVE;
               default:        alu_op = op_q;
            endcase
            if (last_bit) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: operand capture, per-bit shifting, and result/flag load on the final bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         res_sh_q    <= '0;
         result_q    <= '0;
         op_q        <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_sh_q  <= a;
                  b_sh_q  <= b;
                  op_q    <= op;
                  cnt_q   <= '0;
                  carry_q <= (op == OP_SUB);
               end
            end
            S_RUN: begin
               res_sh_q <= res_next[WIDTH-1:1];
               a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
               b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
               carry_q  <= alu_cout;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (last_bit) begin
                  result_q    <= res_next;
                  carry_out_q <= is_arith & alu_cout;
                  zero_q      <= (res_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SERIAL_OVF_EN
   logic ovf_q;

   // Signed overflow = carry into MSB xor carry out of MSB, sampled on the final bit.
   always_ff @(posedge clk) begin
      if (!rst_n)                            ovf_q <= 1'b0;
      else if (state_q == S_RUN && last_bit) ovf_q <= is_arith & (carry_q ^ alu_cout);
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign result    = result_q;
   assign carry_out = carry_out_q;
   assign zero      = zero_q;

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial sequencer that sits directly upstream of the 1-bit ALU slice (move/and/or/xor/add).
- Accepts a WIDTH-bit operand pair and an op code, then presents one bit pair per cycle to the slice, LSB first.
- Carries the slice's carry between cycles and collects the returned result bits into a WIDTH-bit result with flags.
- The 1-bit slice stays purely combinational; all sequencing lives in this block.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, 5, bit counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- op  input  3  000 MOVE, 001 AND, 010 OR, 011 XOR, 100 ADD, 101 SUB; 110/111 reserved, treated as MOVE.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  final result; held until the next accepted start.
- carry_out  output  1  final carry for ADD/SUB; 0 for the other ops.
- zero  output  1  result == 0; updated together with result.
- ovf  output  1  signed overflow (see Optional Feature).
- alu_op  output  3  op forwarded to the slice; SUB is forwarded as ADD.
- alu_a  output  1  current A bit.
- alu_b  output  1  current B bit; inverted for SUB.
- alu_cin  output  1  current carry-in.
- alu_result  input  1  slice result bit (combinational from alu_*).
- alu_cout  input  1  slice carry-out.

Behaviour:
- Reset: synchronous, active-low, on the rising edge of clk with rst_n=0.
  - State goes to IDLE.
  - busy, done, result, carry_out, zero, ovf, all alu_* outputs, shift registers, counter and carry flop all go to 0.
  - Reset during RUN abandons the operation and produces no done.
- States:
  - IDLE -> RUN when start=1. On that edge: latch a into a_sh, b into b_sh, latch op, clear counter.
  - Carry flop initialises to 1 for SUB, 0 otherwise.
  - start in RUN or DONE is ignored and not queued.
- RUN, cycle k = 0..WIDTH-1:
  - Drive alu_a=a_sh[0], alu_b=b_sh[0] (inverted for SUB), alu_cin=carry flop.
  - On the edge: shift alu_result into the result shift register MSB end, shift right.
  - Shift a_sh and b_sh right, carry flop <= alu_cout, counter++.
  - After WIDTH RUN cycles, go to DONE.
- DONE, exactly one cycle:
  - done=1; result/zero/carry_out/ovf are already valid.
  - Next state is IDLE unconditionally.
- Latency: start sampled at edge N -> done high during the cycle after edge N+WIDTH. Back-to-back issue period is WIDTH+2 cycles.
- alu_* outputs are 0 outside RUN.
- Result register update:
  - The result register is separate from the shift register; it loads on the RUN->DONE edge.
  - The prior result stays visible during RUN.
- carry_out:
  - ADD: final carry.
  - SUB: final carry, where 1 means no borrow (a >= b unsigned).
  - Other ops: 0.
- Width rules: result is exactly WIDTH bits; wrap-around is modular and carries are not extended.

Optional Feature:
- Macro: ALU_SERIAL_OVF_EN.
- Defined:
  - During the last RUN cycle, capture carry-in XOR carry-out for ADD/SUB.
  - ovf loads on the RUN->DONE edge, is 0 for logical ops, and is held with result.
- Undefined: ovf is tied to 0 and no extra flop is built.

Test Plan:
- ADD a=8'h7F, b=8'h01, start pulsed -> done exactly 9 cycles after the accepting edge; result=8'h80, carry_out=0, zero=0, ovf=1 (macro on) / 0 (macro off).
- SUB a=8'h05, b=8'h05 -> result=8'h00, zero=1, carry_out=1; alu_cin=1 in the first RUN cycle; alu_op=ADD throughout.
- MOVE a=8'hA5, b=8'hFF, then AND a=8'hF0, b=8'h3C -> results 8'hA5 then 8'h30, carry_out=0 for both; previous result holds during the second RUN.
- ADD a=8'hFF, b=8'h01 with start re-pulsed at RUN cycle 3 -> second start ignored; one done only; result=8'h00, carry_out=1, zero=1.
- Reset mid-operation: rst_n low at RUN cycle 4 of ADD 8'h12+8'h34 -> next edge IDLE, all outputs 0, no done; a new start then yields result=8'h46.
- op=3'b111, a=8'h3C -> behaves as MOVE: result=8'h3C, alu_op=MOVE driven.
